// File: rtl/booth_mult_seq_if.sv
// Start/done handshake and operand/product bus for the sequential Booth multiplier.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     m;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, signed_mode, q, m,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, q, m,
    output busy, done, p
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Operands are extended to WIDTH+2 bits so one Booth recoding covers both modes.
// Build option BOOTH_RADIX4_EN selects radix-4 (modified Booth, two bits per
// cycle); otherwise radix-2 (one bit per cycle).
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_seq_if.slave  bus
);

  localparam int unsigned XW = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
  // Accumulator carries one extra bit so +/-2M never wraps.
  localparam int unsigned AW = WIDTH + 3;
  localparam int unsigned N  = XW / 2;
`else
  localparam int unsigned AW = XW;
  localparam int unsigned N  = XW;
`endif
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [XW-1:0]   qr_q, qr_d;
  logic            qm1_q, qm1_d;
  logic [XW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   p_q, p_d;

  logic [AW-1:0]   a_sum;
  logic [AW-1:0]   a_sh;
  logic [XW-1:0]   q_sh;
  logic            qm1_sh;

  // Sign- or zero-extend an operand to the internal width.
  function automatic logic [XW-1:0] ext(input logic [WIDTH-1:0] x, input logic sm);
    return sm ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m_w;
  logic [AW-1:0] m2_w;

  // One radix-4 iteration: recode {Q[1:0],q-1}, add, arithmetic shift by 2.
  always_comb begin
    m_w  = {m_q[XW-1], m_q};
    m2_w = {m_q, 1'b0};
    case ({qr_q[1:0], qm1_q})
      3'b001, 3'b010: a_sum = a_q + m_w;
      3'b011:         a_sum = a_q + m2_w;
      3'b100:         a_sum = a_q - m2_w;
      3'b101, 3'b110: a_sum = a_q - m_w;
      default:        a_sum = a_q;
    endcase
    a_sh   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    q_sh   = {a_sum[1:0], qr_q[XW-1:2]};
    qm1_sh = qr_q[1];
  end
`else
  // One radix-2 iteration: recode {Q[0],q-1}, add, arithmetic shift by 1.
  always_comb begin
    case ({qr_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_sh   = {a_sum[AW-1], a_sum[AW-1:1]};
    q_sh   = {a_sum[0], qr_q[XW-1:1]};
    qm1_sh = qr_q[0];
  end
`endif

  // Next-state and register update logic; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = ext(bus.m, bus.signed_mode);
          qr_d    = ext(bus.q, bus.signed_mode);
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        qr_d  = q_sh;
        qm1_d = qm1_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          p_d     = PW'({a_sh, q_sh});
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule
